// File: rtl/maxpool_27_2_16_pkg.sv
// maxpool_27_2_16_pkg: default pooling geometry, sample type and counter-width helper
package maxpool_27_2_16_pkg;
  localparam int DEF_T = 16;
  localparam int DEF_SIZE_Y = 27;
  localparam int DEF_POOL = 2;
  localparam int OUT_LEN = DEF_SIZE_Y / DEF_POOL;
  localparam int DISCARD_START = OUT_LEN * DEF_POOL;
  typedef logic signed [DEF_T-1:0] sample_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/maxpool_27_2_16_if.sv
// maxpool_27_2_16_if: x (input stream) and y (pooled stream) valid/ready channels; slave = pooling block, master = bench/upstream side
interface maxpool_27_2_16_if #(parameter int T = 16);
  logic signed [T-1:0] x_data;
  logic x_valid;
  logic x_ready;
  logic signed [T-1:0] y_data;
  logic y_valid;
  logic y_ready;
  modport slave (input x_data, x_valid, y_ready, output x_ready, y_data, y_valid);
  modport master (output x_data, x_valid, y_ready, input x_ready, y_data, y_valid);
endinterface

// File: rtl/maxpool_27_2_16.sv
// maxpool_27_2_16: streaming 1-D signed max-pool (ports: clk, reset active-low sync, s = x/y valid-ready channels), trailing SIZE_Y%POOL samples dropped per frame
module maxpool_27_2_16
  import maxpool_27_2_16_pkg::*;
#(
  parameter int T = DEF_T,
  parameter int SIZE_Y = DEF_SIZE_Y,
  parameter int POOL = DEF_POOL
) (
  input logic clk,
  input logic reset,
  maxpool_27_2_16_if.slave s
);
  localparam int N_OUT = SIZE_Y / POOL;
  localparam int D_START = N_OUT * POOL;
  localparam int WW = cnt_w(POOL);
  localparam int FW = cnt_w(SIZE_Y + 1);
  logic [WW-1:0] r_wcnt;
  logic [FW-1:0] r_fcnt;
  logic signed [T-1:0] r_max, r_y;
  logic r_yv;
  logic w_acc, w_last_w, w_last_f, w_done;
  logic signed [T-1:0] w_new;
  assign s.x_ready = ~r_yv | s.y_ready;
  assign s.y_valid = r_yv;
  assign s.y_data = r_y;
  assign w_acc = s.x_valid & s.x_ready;
  assign w_last_w = r_wcnt == WW'(POOL - 1);
  assign w_last_f = r_fcnt == FW'(SIZE_Y - 1);
  assign w_done = w_acc & w_last_w & (r_fcnt < FW'(D_START));
  // first sample of a window seeds the max; with POOL==1 this is always x_data
  assign w_new = (r_wcnt == '0 || s.x_data > r_max) ? s.x_data : r_max;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wcnt <= '0;
      r_fcnt <= '0;
      r_max <= '0;
      r_y <= '0;
      r_yv <= 1'b0;
    end else begin
      if (w_acc) begin
        r_max <= w_new;
        r_wcnt <= (w_last_w || w_last_f) ? '0 : r_wcnt + 1'b1;
        r_fcnt <= w_last_f ? '0 : r_fcnt + 1'b1;
      end
      if (w_done) begin
        r_y <= w_new;
        r_yv <= 1'b1;
      end else if (s.y_ready) begin
        r_yv <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_27_2_16.sv
// tb_maxpool_27_2_16: directed self-checking bench for POOL=2, POOL=1 and POOL=27 builds
module tb_maxpool_27_2_16;
  import maxpool_27_2_16_pkg::*;
  logic clk, reset;
  int n_err, n_chk;
  maxpool_27_2_16_if #(.T(16)) m ();
  maxpool_27_2_16_if #(.T(16)) m1 ();
  maxpool_27_2_16_if #(.T(16)) m27 ();
  maxpool_27_2_16 #(.T(16), .SIZE_Y(27), .POOL(2)) dut (.clk(clk), .reset(reset), .s(m));
  maxpool_27_2_16 #(.T(16), .SIZE_Y(27), .POOL(1)) dut1 (.clk(clk), .reset(reset), .s(m1));
  maxpool_27_2_16 #(.T(16), .SIZE_Y(27), .POOL(27)) dut27 (.clk(clk), .reset(reset), .s(m27));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send(input sample_t v);
    m.x_data = v;
    m.x_valid = 1'b1;
    @(posedge clk);
    #1;
    m.x_valid = 1'b0;
  endtask
  task automatic basic_frame(input string tag);
    int n = 0;
    m.y_ready = 1'b1;
    for (int i = 0; i < 27; i++) begin
      m.x_data = 16'(i);
      m.x_valid = 1'b1;
      #1;
      chk({tag, "_xrdy"}, m.x_ready, 1);
      @(posedge clk);
      #1;
      n += int'(m.y_valid);
      if (i % 2 == 1) begin
        chk({tag, "_yv"}, m.y_valid, 1);
        chk({tag, "_yd"}, m.y_data, i);
      end else begin
        chk({tag, "_yv0"}, m.y_valid, 0);
      end
    end
    m.x_valid = 1'b0;
    chk({tag, "_count"}, n, 13);
  endtask
  function automatic sample_t val(input int g);
    return sample_t'(((g * 37) % 211) - 105);
  endfunction
  initial begin
    sample_t q[$];
    sample_t a, b, e;
    int g, c, n;
    n_err = 0;
    n_chk = 0;
    reset = 1'b0;
    m.x_data = '0; m.x_valid = 1'b0; m.y_ready = 1'b0;
    m1.x_data = '0; m1.x_valid = 1'b0; m1.y_ready = 1'b1;
    m27.x_data = '0; m27.x_valid = 1'b0; m27.y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_yv", m.y_valid, 0);
    chk("rst_yd", m.y_data, 0);
    chk("rst_xrdy", m.x_ready, 1);
    reset = 1'b1;
    basic_frame("basic");
    m.y_ready = 1'b1;
    send(-16'sd5);
    send(-16'sd3);
    chk("sgn_neg_yv", m.y_valid, 1);
    chk("sgn_neg", m.y_data, -3);
    send(-16'sd32768);
    chk("sgn_mid_yv0", m.y_valid, 0);
    send(16'sd32767);
    chk("sgn_extreme", m.y_data, 32767);
    send(16'sd7);
    send(16'sd7);
    chk("sgn_equal", m.y_data, 7);
    @(posedge clk);
    #1;
    m.y_ready = 1'b0;
    send(16'sd10);
    chk("bp_first_yv0", m.y_valid, 0);
    send(16'sd20);
    chk("bp_pend_yv", m.y_valid, 1);
    chk("bp_pend_yd", m.y_data, 20);
    m.x_data = 16'sd99;
    m.x_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_yv", m.y_valid, 1);
      chk("bp_hold_yd", m.y_data, 20);
      chk("bp_hold_xrdy", m.x_ready, 0);
    end
    m.x_valid = 1'b0;
    m.y_ready = 1'b1;
    #1;
    chk("bp_rel_xrdy", m.x_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_drained_yv", m.y_valid, 0);
    send(16'sd5);
    chk("bp_after_yv0", m.y_valid, 0);
    send(16'sd6);
    chk("bp_after_yv", m.y_valid, 1);
    chk("bp_after_yd", m.y_data, 6);
    send(16'sd10);
    send(16'sd11);
    send(16'sd12);
    m.y_ready = 1'b0;
    send(16'sd13);
    chk("mid_pend_yv", m.y_valid, 1);
    chk("mid_pend_yd", m.y_data, 13);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_rst_yv", m.y_valid, 0);
    chk("mid_rst_yd", m.y_data, 0);
    chk("mid_rst_xrdy", m.x_ready, 1);
    m.y_ready = 1'b1;
    send(16'sd100);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    basic_frame("after_rst");
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 26; j += 2) begin
        a = val(f * 27 + j);
        b = val(f * 27 + j + 1);
        q.push_back(b > a ? b : a);
      end
    g = 0;
    c = 0;
    n = 0;
    m.y_ready = 1'b1;
    while (g < 54 && c < 500) begin
      m.x_valid = (c % 3 != 1);
      m.x_data = val(g);
      @(posedge clk);
      #1;
      if (m.x_valid) g++;
      if (m.y_valid) begin
        n++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_yd", m.y_data, e);
        end
      end
      c++;
    end
    m.x_valid = 1'b0;
    chk("b2b_count", n, 26);
    chk("b2b_consumed", g, 54);
    begin
      sample_t v1[5] = '{-16'sd3, 16'sd5, -16'sd32768, 16'sd32767, 16'sd0};
      for (int i = 0; i < 5; i++) begin
        m1.x_data = v1[i];
        m1.x_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("p1_yv", m1.y_valid, 1);
        chk("p1_yd", m1.y_data, v1[i]);
      end
      m1.x_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("p1_idle_yv", m1.y_valid, 0);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 27; i++) begin
        m27.x_data = (f == 0) ? ((i == 20) ? 16'sd500 : sample_t'(i - 30)) : sample_t'(-i - 1);
        m27.x_valid = 1'b1;
        @(posedge clk);
        #1;
        if (i < 26) chk("p27_yv0", m27.y_valid, 0);
      end
      chk("p27_yv", m27.y_valid, 1);
      chk("p27_yd", m27.y_data, (f == 0) ? 500 : -1);
    end
    m27.x_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
